// File: rtl/bsg_alu_seq.sv
// Handshaked ALU (add/sub/logic/slt/shl) with an iterative shift-add multiplier.
// Latency: 1 cycle for non-MUL ops; width_p+1 cycles for MUL (accept to v_o).
// Backpressure: one op in flight; ready_o stays low until the result is taken with yumi_i.
//
// Ports:
//   clk_i, reset_n_i   clock, synchronous active-low reset
//   v_i / ready_o      operation handshake; op_i, a_i, b_i sampled on accept
//   v_o / yumi_i       result handshake; res_o, ov_o, zero_o held while v_o=1
module bsg_alu_seq #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [2:0]         op_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] res_o,
    output logic               ov_o,
    output logic               zero_o
);

    localparam int cnt_w_lp = $clog2(width_p + 1);

    localparam logic [2:0] op_add_lp = 3'b000;
    localparam logic [2:0] op_sub_lp = 3'b001;
    localparam logic [2:0] op_and_lp = 3'b010;
    localparam logic [2:0] op_or_lp  = 3'b011;
    localparam logic [2:0] op_xor_lp = 3'b100;
    localparam logic [2:0] op_slt_lp = 3'b101;
    localparam logic [2:0] op_shl_lp = 3'b110;
    localparam logic [2:0] op_mul_lp = 3'b111;

    // Shift limit held one bit wider than b so the compare also works at width_p=64.
    localparam logic [width_p:0] width_lp = (width_p + 1)'(width_p);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    state_e                   state_r;
    logic [width_p-1:0]       res_r;
    logic                     ov_r;
    logic [2*width_p-1:0]     mcand_r;
    logic [width_p-1:0]       mplier_r;
    logic [2*width_p-1:0]     acc_r;
    logic [cnt_w_lp-1:0]      cnt_r;

    logic [width_p-1:0]       sum;
    logic [width_p-1:0]       diff;
    logic [2*width_p-1:0]     shl_wide;
    logic                     shl_oor;
    logic [width_p-1:0]       alu_res;
    logic                     alu_ov;
    logic [2*width_p-1:0]     acc_next;

    // Single-cycle datapath, evaluated straight off the input operands so the
    // result can be registered in the accept cycle.
    always_comb begin
        sum      = a_i + b_i;
        diff     = a_i - b_i;
        // Shift in a double-width field so bits pushed out land in the upper half.
        shl_wide = {{width_p{1'b0}}, a_i} << b_i;
        shl_oor  = ({1'b0, b_i} >= width_lp);
        alu_res  = '0;
        alu_ov   = 1'b0;
        case (op_i)
            op_add_lp: begin
                alu_res = sum;
                alu_ov  = (a_i[width_p-1] == b_i[width_p-1]) &&
                          (sum[width_p-1] != a_i[width_p-1]);
            end
            op_sub_lp: begin
                alu_res = diff;
                alu_ov  = (a_i[width_p-1] != b_i[width_p-1]) &&
                          (diff[width_p-1] != a_i[width_p-1]);
            end
            op_and_lp: alu_res = a_i & b_i;
            op_or_lp:  alu_res = a_i | b_i;
            op_xor_lp: alu_res = a_i ^ b_i;
            op_slt_lp: alu_res = {{(width_p-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            op_shl_lp: begin
                if (shl_oor) begin
                    alu_res = '0;
                    alu_ov  = |a_i;
                end else begin
                    alu_res = shl_wide[width_p-1:0];
                    alu_ov  = |shl_wide[2*width_p-1:width_p];
                end
            end
            default: begin
                alu_res = '0;
                alu_ov  = 1'b0;
            end
        endcase
    end

    // One multiplier bit per cycle: add the (pre-shifted) multiplicand when the
    // current LSB of the multiplier is set.
    assign acc_next = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r  <= S_IDLE;
            res_r    <= '0;
            ov_r     <= 1'b0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (v_i && ready_o) begin
                        if (op_i == op_mul_lp) begin
                            mcand_r  <= {{width_p{1'b0}}, a_i};
                            mplier_r <= b_i;
                            acc_r    <= '0;
                            cnt_r    <= cnt_w_lp'(width_p);
                            state_r  <= S_MUL;
                        end else begin
                            res_r   <= alu_res;
                            ov_r    <= alu_ov;
                            state_r <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_r    <= acc_next;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r - 1'b1;
                    // Last iteration: take the final sum directly from acc_next.
                    if (cnt_r == cnt_w_lp'(1)) begin
                        res_r   <= acc_next[width_p-1:0];
                        ov_r    <= |acc_next[2*width_p-1:width_p];
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    // yumi_i outside DONE is illegal and simply not looked at.
                    if (yumi_i) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // ready_o is gated by reset so nothing is offered while reset is asserted.
    assign ready_o = reset_n_i && (state_r == S_IDLE);
    assign v_o     = (state_r == S_DONE);
    assign res_o   = res_r;
    assign ov_o    = ov_r;
    assign zero_o  = (res_r == '0);

endmodule

// File: tb/tb_bsg_alu_seq.sv
// Directed bench for bsg_alu_seq with a queue scoreboard and an independent monitor.
// Latency: expected accept-to-valid latency is carried in each scoreboard entry.
// Backpressure: a consumer process stalls yumi_i for a programmable number of cycles.
module tb_bsg_alu_seq;

    localparam int W = 4;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SLT = 3'b101;
    localparam logic [2:0] SHL = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         v_i = 1'b0;
    logic         ready_o;
    logic [2:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         v_o;
    logic         yumi_i = 1'b0;
    logic [W-1:0] res_o;
    logic         ov_o;
    logic         zero_o;

    typedef struct {
        logic [W-1:0] res;
        logic         ov;
        logic         z;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_cycles = 0;
    logic v_prev = 1'b0;
    int   last_acc = -1;
    bit   check_gap = 1'b0;

    bsg_alu_seq #(.width_p(W)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .v_o      (v_o),
        .yumi_i   (yumi_i),
        .res_o    (res_o),
        .ov_o     (ov_o),
        .zero_o   (zero_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // yumi_i must never be offered without a valid result.
    assert property (@(posedge clk) disable iff (!reset_n) (yumi_i |-> v_o))
    else begin
        errors++;
        $display("FAIL yumi_without_v_o: yumi_i=1 while v_o=0");
    end

    // Consumer: takes the result as soon as it appears, unless told to stall.
    always @(negedge clk) begin
        yumi_i = v_o && (stall_cycles == 0);
        if (v_o && stall_cycles > 0) stall_cycles--;
    end

    // Monitor: each new result is compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (v_o && !v_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: actual v_o=1 res_o=%0h required no result", res_o);
            end else begin
                e = sb.pop_front();
                chk("res",     res_o,            e.res);
                chk("ov",      ov_o,             e.ov);
                chk("zero",    zero_o,           e.z);
                chk("latency", cyc - e.acc_cyc,  e.lat);
            end
        end
        v_prev = v_o;
    end

    // Presents one op and waits (bounded) for it to be accepted. v_i is left high.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic eov, input bit push);
        exp_t e;
        @(negedge clk);
        op_i = op;
        a_i  = a;
        b_i  = b;
        v_i  = 1'b1;
        for (int i = 0; i < 50 && !ready_o; i++) @(negedge clk);
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual ready_o=0 required ready_o=1 within 50 cycles");
            v_i = 1'b0;
            return;
        end
        if (check_gap && last_acc >= 0) chk("accept_gap", cyc - last_acc, 2);
        last_acc = cyc;
        if (push) begin
            e.res     = er;
            e.ov      = eov;
            e.z       = (er == '0);
            e.lat     = (op == MUL) ? W + 1 : 1;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        v_i = 1'b0;
        for (int i = 0; i < 100 && (sb.size() != 0 || v_o); i++) @(negedge clk);
        chk("drain_outstanding", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_v_o",   v_o,     0);
        chk("rst_res",   res_o,   0);
        chk("rst_ov",    ov_o,    0);
        chk("rst_zero",  zero_o,  1);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", ready_o, 1);

        // 1: ADD with overflow, consumer stalls 3 cycles
        stall_cycles = 3;
        issue(ADD, 4'b0111, 4'b0001, 4'b1000, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v_i = 1'b0;
            chk("hold_v_o",   v_o,     1);
            chk("hold_res",   res_o,   4'b1000);
            chk("hold_ov",    ov_o,    1);
            chk("hold_ready", ready_o, 0);
        end
        drain();

        // 2: SUB and SLT
        issue(SUB, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1);
        issue(SUB, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1);
        issue(SLT, 4'b1000, 4'b0001, 4'b0001, 1'b0, 1'b1);
        // logic ops and edge values
        issue(AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1);
        issue(OR,  4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b1);
        issue(XOR, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b1);
        issue(ADD, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        issue(SLT, 4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b1);
        drain();

        // 3: MUL
        issue(MUL, 4'b0101, 4'b0011, 4'b1111, 1'b0, 1'b1);
        issue(MUL, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1);
        issue(MUL, 4'b1111, 4'b1111, 4'b0001, 1'b1, 1'b1);
        drain();

        // 4: SHL
        issue(SHL, 4'b0011, 4'b0010, 4'b1100, 1'b0, 1'b1);
        issue(SHL, 4'b0011, 4'b0011, 4'b1000, 1'b1, 1'b1);
        issue(SHL, 4'b0001, 4'b0100, 4'b0000, 1'b1, 1'b1);
        issue(SHL, 4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b1);
        issue(SHL, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1);
        drain();

        // 5: reset in MUL cycle 2 aborts the multiply
        issue(MUL, 4'b0101, 4'b0011, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        v_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("abort_v_o",   v_o,     0);
        chk("abort_ready", ready_o, 1);
        chk("abort_res",   res_o,   0);
        chk("abort_zero",  zero_o,  1);
        repeat (8) @(negedge clk);
        issue(ADD, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b1);
        drain();

        // 6: v_i held high, consumer takes every result immediately
        check_gap = 1'b1;
        last_acc  = -1;
        issue(ADD, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b1);
        issue(SUB, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b1);
        issue(XOR, 4'b1111, 4'b0101, 4'b1010, 1'b0, 1'b1);
        issue(SLT, 4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b1);
        issue(ADD, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1);
        issue(OR,  4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        check_gap = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_alu_seq.md
Name: bsg_alu_seq

Overview:
Parametrised, handshaked successor to the 2-bit-control combinational ALU. Accepts one operation at a time through a ready/valid input and returns a registered result through a valid/yumi output. Adds signed overflow, zero and shift flags. Adds an iterative shift-add multiplier that runs for width_p cycles. Sits between operand-issue logic and a consumer that may stall.

Parameters:
width_p, 4, operand/result width in bits; legal range 2..64.

Ports:
clk_i  in  1  clock; all state updates on its rising edge.
reset_n_i  in  1  synchronous active-low reset; sampled on the rising edge of clk_i.
v_i  in  1  input operation valid.
ready_o  out  1  block can accept an operation this cycle.
op_i  in  3  opcode, sampled on accept.
a_i  in  width_p  operand A, sampled on accept.
b_i  in  width_p  operand B, sampled on accept.
v_o  out  1  result valid.
yumi_i  in  1  consumer takes the result; legal only when v_o=1.
res_o  out  width_p  result.
ov_o  out  1  overflow flag for the result.
zero_o  out  1  1 when res_o==0.

Behaviour:
- Opcodes:
  - 000 ADD: a+b, ov = signed overflow.
  - 001 SUB: a-b, ov = signed overflow.
  - 010 AND, 011 OR, 100 XOR: ov=0.
  - 101 SLT: res = {0..,1} if signed a<signed b, else 0; ov=0.
  - 110 SHL: a << b, with b treated as unsigned. If b>=width_p, res=0 and ov=(a!=0). Otherwise ov=1 if any 1 bit is shifted out.
  - 111 MUL: unsigned a*b. res = low width_p bits; ov=1 if the high width_p bits are nonzero.
- Arithmetic: ADD/SUB computed at width_p bits and truncated. Signed overflow = operand signs agree (for SUB: a and ~b) and the result sign differs.
- FSM states: IDLE, MUL, DONE.
  - IDLE: ready_o=1, v_o=0. Accept on v_i&ready_o and latch op_i, a_i, b_i.
    - Non-MUL opcode: compute combinationally, register res/ov, go to DONE. v_o=1 in the cycle after accept (latency 1).
    - MUL: go to MUL and load the counter with width_p.
  - MUL: ready_o=0, v_o=0. Each cycle, conditionally add the shifted multiplicand into a 2*width_p accumulator per one multiplier bit, then decrement the counter. After width_p cycles go to DONE. v_o rises width_p+1 cycles after accept.
  - DONE: v_o=1; ready_o=0. res_o, ov_o and zero_o are held stable until yumi_i. On yumi_i go to IDLE; ready_o=1 the next cycle. Sustained throughput for non-MUL ops is therefore one operation per 2 cycles.
- v_i while ready_o=0 is ignored; the operands are not captured.
- yumi_i while v_o=0 is illegal; the bench asserts on it and the RTL ignores it.
- zero_o = (res_o==0), derived from the registered result.
- Reset (reset_n_i=0 on a clock edge):
  - Next state is IDLE.
  - v_o=0, res_o=0, ov_o=0, zero_o=1.
  - ready_o is forced to 0 in any cycle where reset_n_i=0.
  - Reset during MUL or DONE aborts the operation; no v_o pulse follows.
- Operation never observed before the first rising edge with reset_n_i=1.

Test Plan:
1. width_p=4. ADD a=0111, b=0001, accept at cycle N → v_o=1 at N+1, res=1000, ov=1, zero=0. Hold yumi_i=0 for 3 cycles → outputs stable and ready_o=0 throughout.
2. SUB a=0000, b=0001 → res=1111, ov=0. SUB a=1000, b=0001 → res=0111, ov=1. SLT a=1000, b=0001 → res=0001.
3. MUL a=0101, b=0011, accept at cycle N → v_o first high at N+5, res=1111, ov=0. MUL a=0100, b=0100 → res=0000, ov=1, zero=1.
4. SHL a=0011, b=0010 → res=1100, ov=0. a=0011, b=0011 → res=1000, ov=1. a=0001, b=0100 → res=0000, ov=1, zero=1.
5. Assert reset_n_i=0 for 1 cycle at MUL cycle 2 → next cycle v_o=0, ready_o=1. No result appears. The next ADD 0001+0001 returns 0010 normally.
6. Hold v_i=1 continuously with an op sequence; assert yumi_i the same cycle v_o rises. Exactly one accept per 2 cycles; results match the scoreboard in order; no op lost or duplicated.
